// File: rtl/interrupt_ctrl_up.sv
// interrupt_ctrl_up: prioritised, maskable, non-nesting interrupt controller driving the microcode intp condition
module interrupt_ctrl_up #(
    parameter int                N_SRC    = 4,
    parameter int                VEC_W    = 8,
    parameter logic [VEC_W-1:0]  VEC_BASE = 8'h10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_din,
    input  logic             gie_set,
    input  logic             gie_clr,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             intp,
    output logic [VEC_W-1:0] vector,
    output logic             busy,
    output logic [N_SRC-1:0] pending
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_nx;
    logic [N_SRC-1:0] irq_q, mask, elig, rise, clr;
    logic [2:0]       win;
    logic [VEC_W-1:0] vec_nx;
    logic             gie, gie_nx, any, ack, done;

    assign rise = irq & ~irq_q;
    assign elig = gie ? pending & mask : '0;
    assign any  = |elig;
    // an ack that lands on a stale intp (request already withdrawn) is dropped
    assign ack  = state == REQ && int_ack && any;
    assign done = state == SERVICE && eoi;

    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (elig[i]) win = 3'(i);
    end

    assign clr    = ack ? N_SRC'(1) << win : '0;
    assign vec_nx = VEC_BASE + VEC_W'({win, 2'b00});

    always_comb begin
        state_nx = state;
        gie_nx   = gie;
        state_nx = ack ? SERVICE : done ? IDLE : state == SERVICE ? SERVICE : any ? REQ : IDLE;
        gie_nx   = ack ? 1'b0 : done ? 1'b1 : gie_clr ? 1'b0 : gie_set ? 1'b1 : gie;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
            gie     <= 1'b0;
            intp    <= 1'b0;
            busy    <= 1'b0;
            vector  <= '0;
        end else begin
            state   <= state_nx;
            irq_q   <= irq;
            pending <= (pending & ~clr) | rise;
            if (mask_we) mask <= mask_din;
            gie     <= gie_nx;
            intp    <= state_nx == REQ;
            busy    <= state_nx == SERVICE;
            if (ack) vector <= vec_nx;
        end
    end
endmodule

// File: tb/tb_interrupt_ctrl_up.sv
// tb_interrupt_ctrl_up: directed scenarios plus randomized run against a behavioural model
module tb_interrupt_ctrl_up;
    logic       clk, rst, mask_we, gie_set, gie_clr, int_ack, eoi;
    logic [3:0] irq, mask_din;
    logic       intp, busy;
    logic [7:0] vector;
    logic [3:0] pending;
    int checks = 0, passes = 0;

    interrupt_ctrl_up dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_din(mask_din),
        .gie_set(gie_set), .gie_clr(gie_clr), .int_ack(int_ack), .eoi(eoi),
        .intp(intp), .vector(vector), .busy(busy), .pending(pending)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // model: intp follows "something eligible while not in service", ack picks lowest eligible index
    logic [3:0] m_pend, m_mask, m_irq_q;
    logic [7:0] m_vec;
    bit         m_gie, m_req, m_busy;
    always @(posedge clk or negedge rst) begin
        logic [3:0] el, rs;
        int w;
        bit a, d;
        if (!rst) begin
            m_pend = 0; m_mask = 0; m_irq_q = 0; m_vec = 0; m_gie = 0; m_req = 0; m_busy = 0;
        end else begin
            el = m_gie ? m_pend & m_mask : 4'h0;
            w = -1;
            for (int i = 3; i >= 0; i--) if (el[i]) w = i;
            rs = irq & ~m_irq_q;
            a = m_req && int_ack && w >= 0;
            d = m_busy && eoi;
            if (a) m_pend[w] = 1'b0;
            m_pend = m_pend | rs;
            m_irq_q = irq;
            if (mask_we) m_mask = mask_din;
            m_gie = a ? 1'b0 : d ? 1'b1 : gie_clr ? 1'b0 : gie_set ? 1'b1 : m_gie;
            if (a) begin
                m_busy = 1; m_req = 0; m_vec = 8'h10 + 8'(w * 4);
            end else if (d) begin
                m_busy = 0; m_req = 0;
            end else if (!m_busy) m_req = w >= 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        mask_we = 0; gie_set = 0; gie_clr = 0; int_ack = 0; eoi = 0;
    endtask

    task automatic test_reset;
        idle_inputs(); mask_din = 0; irq = 4'hF; rst = 0;
        tick(); tick();
        checks++; if (intp !== 1'b0) $display("FAIL reset_intp: got %b want 0", intp); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (vector !== 8'h00) $display("FAIL reset_vector: got %h want 00", vector); else passes++;
        checks++; if (pending !== 4'h0) $display("FAIL reset_pending: got %b want 0000", pending); else passes++;
        rst = 1;
        tick();
        checks++; if (pending !== 4'hF) $display("FAIL release_pending: got %b want 1111", pending); else passes++;
        tick(); tick();
        checks++; if (intp !== 1'b0) $display("FAIL release_intp: got %b want 0", intp); else passes++;
        irq = 0; rst = 0;
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_basic;
        mask_we = 1; mask_din = 4'b0100; gie_set = 1;
        tick(); idle_inputs();
        irq = 4'b0100;
        tick(); irq = 0;
        checks++; if (pending !== 4'b0100) $display("FAIL basic_pend: got %b want 0100", pending); else passes++;
        checks++; if (intp !== 1'b0) $display("FAIL basic_intp_e0: got %b want 0", intp); else passes++;
        tick();
        checks++; if (intp !== 1'b1) $display("FAIL basic_intp_e1: got %b want 1", intp); else passes++;
        int_ack = 1;
        tick(); int_ack = 0;
        checks++; if (vector !== 8'h18) $display("FAIL basic_vector: got %h want 18", vector); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passes++;
        checks++; if (pending !== 4'b0000) $display("FAIL basic_pend_clr: got %b want 0000", pending); else passes++;
        checks++; if (intp !== 1'b0) $display("FAIL basic_intp_ack: got %b want 0", intp); else passes++;
        eoi = 1;
        tick(); eoi = 0;
        checks++; if (busy !== 1'b0) $display("FAIL basic_eoi_busy: got %b want 0", busy); else passes++;
        tick();
        checks++; if (intp !== 1'b0) $display("FAIL basic_quiet: got %b want 0", intp); else passes++;
    endtask

    task automatic test_priority;
        mask_we = 1; mask_din = 4'b1111; irq = 4'b1010;
        tick(); idle_inputs(); irq = 0;
        tick();
        checks++; if (intp !== 1'b1) $display("FAIL prio_intp: got %b want 1", intp); else passes++;
        int_ack = 1;
        tick(); int_ack = 0;
        checks++; if (vector !== 8'h14) $display("FAIL prio_vec1: got %h want 14", vector); else passes++;
        checks++; if (pending !== 4'b1000) $display("FAIL prio_pend1: got %b want 1000", pending); else passes++;
        eoi = 1;
        tick(); eoi = 0;
        checks++; if (intp !== 1'b0) $display("FAIL prio_eoi_intp: got %b want 0", intp); else passes++;
        tick();
        checks++; if (intp !== 1'b1) $display("FAIL prio_rearm: got %b want 1", intp); else passes++;
        int_ack = 1;
        tick(); int_ack = 0;
        checks++; if (vector !== 8'h1C) $display("FAIL prio_vec2: got %h want 1c", vector); else passes++;
        checks++; if (pending !== 4'b0000) $display("FAIL prio_pend2: got %b want 0000", pending); else passes++;
        eoi = 1;
        tick(); eoi = 0;
    endtask

    task automatic test_withdraw;
        irq = 4'b0001;
        tick(); irq = 0;
        tick();
        checks++; if (intp !== 1'b1) $display("FAIL wd_intp: got %b want 1", intp); else passes++;
        mask_we = 1; mask_din = 4'b0000;
        tick(); mask_we = 0;
        checks++; if (intp !== 1'b1) $display("FAIL wd_stale: got %b want 1", intp); else passes++;
        tick();
        checks++; if (intp !== 1'b0) $display("FAIL wd_drop: got %b want 0", intp); else passes++;
        mask_we = 1; mask_din = 4'b1111;
        tick(); mask_we = 0;
        checks++; if (intp !== 1'b0) $display("FAIL wd_idle: got %b want 0", intp); else passes++;
        tick();
        checks++; if (intp !== 1'b1) $display("FAIL wd_return: got %b want 1", intp); else passes++;
        int_ack = 1;
        tick(); int_ack = 0;
        checks++; if (vector !== 8'h10) $display("FAIL wd_vector: got %h want 10", vector); else passes++;
        eoi = 1;
        tick(); eoi = 0;
    endtask

    task automatic test_boundary;
        eoi = 1;
        tick(); eoi = 0;
        checks++; if (busy !== 1'b0 || intp !== 1'b0) $display("FAIL eoi_idle: got busy=%b intp=%b want 0 0", busy, intp); else passes++;
        checks++; if (vector !== 8'h10) $display("FAIL eoi_idle_vec: got %h want 10", vector); else passes++;
        irq = 4'b0100;
        tick(); irq = 0;
        tick();
        int_ack = 1;
        tick();
        tick(); int_ack = 0;
        checks++; if (busy !== 1'b1 || vector !== 8'h18) $display("FAIL ack_in_service: got busy=%b vec=%h want 1 18", busy, vector); else passes++;
        gie_set = 1; irq = 4'b0100;
        tick(); gie_set = 0; irq = 0;
        checks++; if (intp !== 1'b0 || pending !== 4'b0100) $display("FAIL svc_latch: got intp=%b pend=%b want 0 0100", intp, pending); else passes++;
        tick();
        checks++; if (intp !== 1'b0) $display("FAIL svc_no_rearm: got %b want 0", intp); else passes++;
        eoi = 1;
        tick(); eoi = 0;
        tick();
        checks++; if (intp !== 1'b1) $display("FAIL eoi_rearm: got %b want 1", intp); else passes++;
        int_ack = 1; irq = 4'b0100;
        tick(); int_ack = 0; irq = 0;
        checks++; if (pending !== 4'b0100 || vector !== 8'h18) $display("FAIL set_beats_clr: got pend=%b vec=%h want 0100 18", pending, vector); else passes++;
        eoi = 1;
        tick(); eoi = 0;
        tick();
        int_ack = 1;
        tick(); int_ack = 0;
        eoi = 1;
        tick(); eoi = 0;
        gie_clr = 1;
        tick();
        gie_set = 1;
        tick(); idle_inputs();
        irq = 4'b1000;
        tick(); irq = 0;
        tick(); tick();
        checks++; if (intp !== 1'b0 || pending !== 4'b1000) $display("FAIL gie_set_clr: got intp=%b pend=%b want 0 1000", intp, pending); else passes++;
        gie_set = 1;
        tick(); gie_set = 0;
        tick();
        checks++; if (intp !== 1'b1) $display("FAIL gie_reenable: got %b want 1", intp); else passes++;
        int_ack = 1;
        tick(); int_ack = 0;
        checks++; if (vector !== 8'h1C || busy !== 1'b1) $display("FAIL gie_ack: got vec=%h busy=%b want 1c 1", vector, busy); else passes++;
    endtask

    task automatic test_reset_mid;
        irq = 4'b0001;
        tick();
        rst = 0;
        #1;
        checks++; if (busy !== 1'b0 || intp !== 1'b0) $display("FAIL rmid_busy: got busy=%b intp=%b want 0 0", busy, intp); else passes++;
        checks++; if (vector !== 8'h00) $display("FAIL rmid_vector: got %h want 00", vector); else passes++;
        checks++; if (pending !== 4'h0) $display("FAIL rmid_pending: got %b want 0000", pending); else passes++;
        tick();
        rst = 1;
        tick(); irq = 0;
        checks++; if (pending !== 4'b0001) $display("FAIL rmid_edge: got %b want 0001", pending); else passes++;
        tick(); tick();
        checks++; if (intp !== 1'b0) $display("FAIL rmid_gie: got %b want 0", intp); else passes++;
        gie_set = 1;
        tick(); gie_set = 0;
        tick();
        checks++; if (intp !== 1'b0) $display("FAIL rmid_mask: got %b want 0", intp); else passes++;
        mask_we = 1; mask_din = 4'b0001;
        tick(); mask_we = 0;
        tick();
        checks++; if (intp !== 1'b1) $display("FAIL rmid_restore: got %b want 1", intp); else passes++;
    endtask

    task automatic test_random;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) irq = 4'($urandom_range(0, 15));
            mask_we  = $urandom_range(0, 9) == 0;
            mask_din = 4'($urandom_range(0, 15));
            gie_set  = $urandom_range(0, 4) == 0;
            gie_clr  = $urandom_range(0, 14) == 0;
            int_ack  = m_req ? $urandom_range(0, 3) != 0 : $urandom_range(0, 19) == 0;
            eoi      = m_busy ? $urandom_range(0, 3) == 0 : $urandom_range(0, 19) == 0;
            rst      = $urandom_range(0, 299) != 0;
            tick();
            checks++; if (intp !== m_req) $display("FAIL rnd_intp @%0d: got %b want %b", n, intp, m_req); else passes++;
            checks++; if (busy !== m_busy) $display("FAIL rnd_busy @%0d: got %b want %b", n, busy, m_busy); else passes++;
            checks++; if (vector !== m_vec) $display("FAIL rnd_vector @%0d: got %h want %h", n, vector, m_vec); else passes++;
            checks++; if (pending !== m_pend) $display("FAIL rnd_pending @%0d: got %b want %b", n, pending, m_pend); else passes++;
        end
        rst = 1; idle_inputs();
    endtask

    initial begin
        rst = 0; irq = 0; mask_din = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_basic();
        test_priority();
        test_withdraw();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/interrupt_ctrl_up.md
# interrupt_ctrl_up

- Prioritised, maskable interrupt controller that drives the `intp` jump condition of the microprogrammed control unit.
- Captures rising edges on up to `N_SRC` external request lines into pending latches.
- Raises `intp` when an enabled request exists, then hands the winning source's vector to the datapath on microcode acknowledge.
- Holds off further interrupts until the ISR signals end-of-interrupt; no nesting.

## Interface

Parameters:
- `N_SRC`, default 4: number of interrupt sources (1..8); index 0 has highest priority.
- `VEC_W`, default 8: vector width, matching the PC width.
- `VEC_BASE`, default 8'h10: vector of source 0.

Ports (reset is asynchronous and active-low):
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous active-low reset.
- `irq` in `N_SRC`: request lines, already synchronous to `clk`; rising-edge triggered.
- `mask_we` in 1: write strobe for the mask register.
- `mask_din` in `N_SRC`: mask value (1 = source enabled).
- `gie_set` in 1: microcode strobe, global enable on.
- `gie_clr` in 1: microcode strobe, global enable off.
- `int_ack` in 1: microcode accepts the interrupt (asserted in the cycle it branches on `intp`).
- `eoi` in 1: microcode end-of-interrupt (return from ISR).
- `intp` out 1: registered interrupt request to the control unit's jcond mux.
- `vector` out `VEC_W`: ISR entry address, valid while `busy`=1.
- `busy` out 1: an ISR is in service.
- `pending` out `N_SRC`: pending latch contents, for status readout.

## Operation

- **Edge capture:** `irq_q` registers `irq` each cycle. If `irq[i]` & ~`irq_q[i]`, set `pending[i]`.
  - An `irq` line already high when reset deasserts counts as a rising edge.
- **Mask:** `mask` loads `mask_din` on `mask_we`. Masked sources still latch pending; they are only excluded from selection.
- **GIE:**
  - Set by `gie_set`, cleared by `gie_clr`; `gie_clr` wins if both are asserted.
  - Also cleared automatically on acknowledge and set automatically on `eoi`.
- **Eligibility:** `elig` = `pending` & `mask` when `gie`=1, else 0. The winner is the lowest index set in `elig`.
- **State machine:**
  - **IDLE:** if `elig`≠0, go to REQ and `intp`←1. Otherwise stay.
  - **REQ:**
    - If `int_ack`: go to SERVICE. Latch the winner index as computed in this cycle (not when REQ was entered). Clear that `pending` bit, `gie`←0, `intp`←0, `busy`←1, `vector`←`VEC_BASE` + (idx<<2), truncated modulo 2^`VEC_W`.
    - Else if `elig`=0 (request masked or `gie` cleared): go to IDLE, `intp`←0.
    - Else stay with `intp`=1.
  - **SERVICE:** `intp` is held at 0 and new edges still latch as pending. On `eoi`: go to IDLE, `busy`←0, `gie`←1. `vector` holds its last value.
- **Ignored strobes:** `int_ack` outside REQ and `eoi` outside SERVICE have no effect.
- **Simultaneous set/clear:** a new rising edge on the acknowledged source in the ack cycle leaves its `pending` bit set (set beats clear).
- **`gie_set` in SERVICE:** updates `gie` but does not re-arm `intp` until `eoi`. `eoi` then forces `gie`=1 regardless.
- **Reset values:** `pending`=0, `mask`=0 (all disabled), `gie`=0, `irq_q`=0, state IDLE, `intp`=0, `vector`=0, `busy`=0.
- **Reset mid-operation:** reset mid-ISR returns everything to these values immediately and loses the in-service source.

## Timing

- `irq[i]` high before edge E0 sets `pending[i]` at E0; with `elig` nonzero, `intp`=1 after E1. Request-to-`intp` latency is 2 edges.
- `int_ack` sampled at edge Ea: after Ea, `intp`=0, `busy`=1 and `vector` is valid. The microcode may load PC from `vector` in the cycle after Ea.
- `eoi` sampled at edge Ee: `busy`=0 after Ee. If another source is eligible, `intp`=1 after Ee+1.
- Mask or GIE clear applied at edge Em while in REQ: `intp`=0 after Em+1. Worst-case stale `intp` is one cycle; the microcode must not ack in that cycle without checking `busy` afterwards.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan

- **Reset defaults:** `rst` low with `irq`=4'b1111 → all outputs 0. Release `rst`, mask=0 → `pending`=4'b1111, `intp` stays 0.
- **Basic flow:** `mask`=4'b0100, `gie_set`, pulse `irq[2]` → `intp`=1 two edges later. `int_ack` → `vector`=8'h18, `busy`=1, `pending[2]`=0, `intp`=0. `eoi` → `busy`=0.
- **Priority:** `mask`=4'b1111, `gie`=1, `irq[3]` and `irq[1]` rise together → ack gives `vector`=8'h14. After `eoi`, `intp` re-asserts and the next ack gives `vector`=8'h1C.
- **Withdrawal:** in REQ with only `irq[0]` pending, write `mask`=0 → `intp` drops after one edge, state IDLE. Restore the mask → `intp` returns.
- **Boundary strobes:**
  - `eoi` in IDLE and `int_ack` in SERVICE → no change.
  - Rising `irq[2]` in the ack cycle of source 2 → `pending[2]`=1 after the ack.
  - `gie_set`+`gie_clr` together → `gie`=0.
- **Reset mid-ISR:** during SERVICE, pulse `rst` low for 1 cycle → `busy`, `vector`, `pending`, `mask` and `gie` are 0 immediately.
